// File: rtl/scale_fifo_sync.sv
// scale_fifo_sync: single-clock first-word-fall-through FIFO for the scaler
// datapath. Storage is a 2^DEPTH_W-word RAM with a registered read port,
// followed by a one-word output stage. The total held count ("level") covers
// the RAM, the RAM read register and the output stage. It never exceeds
// 2^DEPTH_W.
//
// Optional feature macro: SCALE_FIFO_ERR_EN
//   defined   -> sticky ovf_err / udf_err flags, cleared by err_clr
//   undefined -> ovf_err / udf_err tied low, err_clr ignored
module scale_fifo_sync #(
    parameter int DATA_W   = 16,
    parameter int DEPTH_W  = 11,
    parameter int AFULL_TH = (1 << DEPTH_W) - 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_vld,
    input  logic              rd_en,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic [DEPTH_W:0]  level,
    output logic              almost_full,
    input  logic              err_clr,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int              DEPTH   = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] DEPTH_L = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W:0] AFULL_L = (DEPTH_W + 1)'(AFULL_TH);
    localparam logic [DEPTH_W:0] ONE_L   = {{DEPTH_W{1'b0}}, 1'b1};
    localparam logic [DEPTH_W-1:0] PTR_ONE = {{(DEPTH_W - 1){1'b0}}, 1'b1};

    // RAM array and its registered read port (no reset: plain block RAM)
    logic [DATA_W-1:0]  ram_q [DEPTH];
    logic [DATA_W-1:0]  ram_rd_q;

    logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W:0]   level_q, level_d;
    logic               wr_vld_q, wr_vld_d;
    logic               afull_q, afull_d;
    logic               mid_vld_q, mid_vld_d;   // ram_rd_q holds a live word
    logic               out_vld_q, out_vld_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;

    logic               wr_acc_s;
    logic               pop_s;
    logic               mid_move_s;
    logic [DEPTH_W:0]   held_s;
    logic               ram_issue_s;
    logic               ram_we_s;
    logic               ram_re_s;

    // Handshake decode and next-state of pointers, level and the two output stages
    always_comb begin
        wr_acc_s   = wr_en && wr_vld_q;
        pop_s      = rd_en && out_vld_q;
        // Read-register word moves forward when the output stage is empty or being popped
        mid_move_s = mid_vld_q && (!out_vld_q || pop_s);
        held_s     = {{DEPTH_W{1'b0}}, mid_vld_q} + {{DEPTH_W{1'b0}}, out_vld_q};
        // Issue a RAM read when the RAM still holds words and the read register frees up
        ram_issue_s = (level_q > held_s) && (!mid_vld_q || mid_move_s);
        ram_we_s    = wr_acc_s && !flush;
        ram_re_s    = ram_issue_s && !flush;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        mid_vld_d  = mid_vld_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        wr_vld_d   = wr_vld_q;
        afull_d    = afull_q;

        if (flush) begin
            wr_ptr_d   = {DEPTH_W{1'b0}};
            rd_ptr_d   = {DEPTH_W{1'b0}};
            level_d    = {(DEPTH_W + 1){1'b0}};
            mid_vld_d  = 1'b0;
            out_vld_d  = 1'b0;
            out_data_d = {DATA_W{1'b0}};
            wr_vld_d   = 1'b1;
            afull_d    = 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (ram_issue_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            if (wr_acc_s && !pop_s) begin
                level_d = level_q + ONE_L;
            end else if (!wr_acc_s && pop_s) begin
                level_d = level_q - ONE_L;
            end else begin
                level_d = level_q;
            end

            if (ram_issue_s) begin
                mid_vld_d = 1'b1;
            end else if (mid_move_s) begin
                mid_vld_d = 1'b0;
            end else begin
                mid_vld_d = mid_vld_q;
            end

            // rd_data only changes when a new word enters the output stage
            if (mid_move_s) begin
                out_vld_d  = 1'b1;
                out_data_d = ram_rd_q;
            end else if (pop_s) begin
                out_vld_d  = 1'b0;
                out_data_d = out_data_q;
            end else begin
                out_vld_d  = out_vld_q;
                out_data_d = out_data_q;
            end

            wr_vld_d = (level_d < DEPTH_L);
            afull_d  = (level_d >= AFULL_L);
        end
    end

    // RAM write port and registered read port
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_q[wr_ptr_q] <= wr_data;
        end
        if (ram_re_s) begin
            ram_rd_q <= ram_q[rd_ptr_q];
        end
    end

    // Control and output-stage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= {DEPTH_W{1'b0}};
            rd_ptr_q   <= {DEPTH_W{1'b0}};
            level_q    <= {(DEPTH_W + 1){1'b0}};
            wr_vld_q   <= 1'b1;
            afull_q    <= 1'b0;
            mid_vld_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            wr_vld_q   <= wr_vld_d;
            afull_q    <= afull_d;
            mid_vld_q  <= mid_vld_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    assign wr_vld      = wr_vld_q;
    assign rd_vld      = out_vld_q;
    assign rd_data     = out_data_q;
    assign level       = level_q;
    assign almost_full = afull_q;

`ifdef SCALE_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Sticky error flags: a new offence wins over err_clr, flush leaves them alone
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (flush) begin
            ovf_d = ovf_q;
            udf_d = udf_q;
        end else begin
            if (wr_en && !wr_vld_q) begin
                ovf_d = 1'b1;
            end else if (err_clr) begin
                ovf_d = 1'b0;
            end else begin
                ovf_d = ovf_q;
            end

            if (rd_en && !out_vld_q) begin
                udf_d = 1'b1;
            end else if (err_clr) begin
                udf_d = 1'b0;
            end else begin
                udf_d = udf_q;
            end
        end
    end

    // Error flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`else
    logic err_clr_unused_s;
    assign err_clr_unused_s = err_clr;
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_scale_fifo_sync.sv
// Self-checking bench for scale_fifo_sync (DATA_W=16, DEPTH_W=4, AFULL_TH=12).
// A vector table covers fill / overflow / full-with-pop / drain; short
// hand-written sequences cover latency, error flags, flush and reset; a
// queue model checks a random-pop run across pointer wrap.
module tb_scale_fifo_sync;

`ifdef SCALE_FIFO_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, wr_en, rd_en, err_clr;
    logic [15:0] wr_data;
    logic        wr_vld, rd_vld, almost_full, ovf_err, udf_err;
    logic [15:0] rd_data;
    logic [4:0]  level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    scale_fifo_sync #(.DATA_W(16), .DEPTH_W(4), .AFULL_TH(12)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .wr_vld(wr_vld),
        .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data),
        .level(level), .almost_full(almost_full),
        .err_clr(err_clr), .ovf_err(ovf_err), .udf_err(udf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [15:0] wr_data;
        logic        rd_en;
        logic        exp_vld;
        logic        chk_data;
        logic [15:0] exp_data;
        logic [4:0]  exp_level;
        logic        exp_wr_vld;
        logic        exp_af;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        int          avail;
    } ent_t;

    vec_t tbl [34];
    ent_t mq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wr_vld"}, {31'd0, wr_vld}, 32'd1);
        chk({tag, "_rd_vld"}, {31'd0, rd_vld}, 32'd0);
        chk({tag, "_rd_data"}, {16'd0, rd_data}, 32'd0);
        chk({tag, "_level"}, {27'd0, level}, 32'd0);
        chk({tag, "_afull"}, {31'd0, almost_full}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, ovf_err}, 32'd0);
        chk({tag, "_udf"}, {31'd0, udf_err}, 32'd0);
    endtask

    initial begin
        logic m_vld, wacc, pacc;
        int   wrote, budget;

        // Fill 0..15, drop 0xDEAD, full with pop, then write+pop, then drain
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{1'b1, 16'(i), 1'b0, (i >= 2), 1'b1, 16'h0000,
                       5'(i + 1), (i + 1 < 16), (i + 1 >= 12)};
        end
        tbl[16] = '{1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b1, 16'h0000, 5'd16, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1, 16'h0001, 5'd15, 1'b1, 1'b1};
        tbl[18] = '{1'b1, 16'h0010, 1'b1, 1'b1, 1'b1, 16'h0002, 5'd15, 1'b1, 1'b1};
        for (int k = 0; k < 15; k++) begin
            tbl[19 + k] = '{1'b0, 16'h0000, 1'b1, (k < 14), (k < 14), 16'(k + 3),
                            5'(14 - k), 1'b1, (14 - k >= 12)};
        end

        // Reset values
        do_reset();
        chk_reset("rst0");

        // Single write latency
        wr_en = 1'b1; wr_data = 16'h1234;
        step();
        idle_inputs();
        chk("lat_e0_vld", {31'd0, rd_vld}, 32'd0);
        chk("lat_e0_level", {27'd0, level}, 32'd1);
        step();
        chk("lat_e1_vld", {31'd0, rd_vld}, 32'd0);
        step();
        chk("lat_e2_vld", {31'd0, rd_vld}, 32'd1);
        chk("lat_e2_data", {16'd0, rd_data}, 32'h1234);
        chk("lat_e2_level", {27'd0, level}, 32'd1);
        chk("lat_e2_wr_vld", {31'd0, wr_vld}, 32'd1);

        // Vector table
        do_reset();
        for (int i = 0; i < 34; i++) begin
            wr_en = tbl[i].wr_en; wr_data = tbl[i].wr_data; rd_en = tbl[i].rd_en;
            step();
            chk($sformatf("vec%0d_vld", i), {31'd0, rd_vld}, {31'd0, tbl[i].exp_vld});
            if (tbl[i].chk_data) begin
                chk($sformatf("vec%0d_data", i), {16'd0, rd_data}, {16'd0, tbl[i].exp_data});
            end
            chk($sformatf("vec%0d_level", i), {27'd0, level}, {27'd0, tbl[i].exp_level});
            chk($sformatf("vec%0d_wr_vld", i), {31'd0, wr_vld}, {31'd0, tbl[i].exp_wr_vld});
            chk($sformatf("vec%0d_afull", i), {31'd0, almost_full}, {31'd0, tbl[i].exp_af});
        end
        idle_inputs();
        chk("tbl_ovf", {31'd0, ovf_err}, {31'd0, ERR_EN});
        chk("tbl_udf", {31'd0, udf_err}, 32'd0);

        // Underflow flag, clear, and set-wins-over-clear
        do_reset();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("udf_set", {31'd0, udf_err}, {31'd0, ERR_EN});
        chk("udf_level", {27'd0, level}, 32'd0);
        chk("udf_rd_vld", {31'd0, rd_vld}, 32'd0);
        chk("udf_rd_data", {16'd0, rd_data}, 32'd0);
        err_clr = 1'b1;
        step();
        chk("udf_clr", {31'd0, udf_err}, 32'd0);
        rd_en = 1'b1;
        step();
        chk("udf_set_wins", {31'd0, udf_err}, {31'd0, ERR_EN});
        rd_en = 1'b0;
        step();
        err_clr = 1'b0;
        chk("udf_clr2", {31'd0, udf_err}, 32'd0);
        chk("udf_ovf_quiet", {31'd0, ovf_err}, 32'd0);

        // Random pops across pointer wrap, checked against a queue model
        do_reset();
        mq.delete();
        wrote = 0;
        budget = 0;
        while ((wrote < 40 || mq.size() > 0) && budget < 600) begin
            m_vld   = (mq.size() > 0) && (cyc >= mq[0].avail);
            wr_en   = (wrote < 40) ? ($urandom_range(0, 3) != 0) : 1'b0;
            wr_data = 16'h0100 + 16'(wrote);
            rd_en   = (wrote < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
            wacc    = wr_en && (mq.size() < 16);
            pacc    = rd_en && m_vld;
            step();
            if (pacc) begin
                void'(mq.pop_front());
            end
            if (wacc) begin
                mq.push_back('{wr_data, cyc + 2});
                wrote++;
            end
            m_vld = (mq.size() > 0) && (cyc >= mq[0].avail);
            chk($sformatf("rnd%0d_level", budget), {27'd0, level}, 32'(mq.size()));
            chk($sformatf("rnd%0d_vld", budget), {31'd0, rd_vld}, {31'd0, m_vld});
            if (m_vld) begin
                chk($sformatf("rnd%0d_data", budget), {16'd0, rd_data}, {16'd0, mq[0].d});
            end
            budget++;
        end
        chk("rnd_budget", 32'(budget < 600), 32'd1);
        idle_inputs();

        // Flush with a same-cycle write; error flags survive flush
        do_reset();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 16'h00A0 + 16'(i);
            step();
        end
        wr_en = 1'b0;
        step();
        chk("pre_flush_level", {27'd0, level}, 32'd5);
        chk("pre_flush_vld", {31'd0, rd_vld}, 32'd1);
        chk("pre_flush_data", {16'd0, rd_data}, 32'h00A0);
        flush = 1'b1; wr_en = 1'b1; wr_data = 16'h0055;
        step();
        idle_inputs();
        chk("flush_level", {27'd0, level}, 32'd0);
        chk("flush_vld", {31'd0, rd_vld}, 32'd0);
        chk("flush_data", {16'd0, rd_data}, 32'd0);
        chk("flush_wr_vld", {31'd0, wr_vld}, 32'd1);
        chk("flush_udf_kept", {31'd0, udf_err}, {31'd0, ERR_EN});
        step();
        step();
        step();
        chk("post_flush_level", {27'd0, level}, 32'd0);
        chk("post_flush_vld", {31'd0, rd_vld}, 32'd0);

        // Reset in the middle of a burst
        do_reset();
        rd_en = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 16'h0C00 + 16'(i); rd_en = (i >= 4);
            step();
        end
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h0777;
        step();
        rst = 1'b0;
        idle_inputs();
        chk_reset("rst_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scale_fifo_sync.md
# scale_fifo_sync

Parametrised single-clock prefetch (first-word-fall-through) FIFO for the scaler datapath, the single-clock successor of the fixed 16-bit/2K prefetch FIFO used between scaler stages. It generalises data width, depth and almost-full threshold, and adds a fill level, an almost-full flag, a synchronous flush and optional sticky error flags. It sits between line-buffer producers and scaler consumers that run on the same clock.

## Interface
- DATA_W, 16, data width in bits (1..1152)
- DEPTH_W, 11, log2 of total capacity; DEPTH = 2^DEPTH_W words (4..20)
- AFULL_TH, 2^DEPTH_W - 4, almost-full threshold in words (1..DEPTH)

- clk  input  1  single clock; all logic on its rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous content clear
- wr_en  input  1  write request
- wr_data  input  DATA_W  write data
- wr_vld  output  1  space available; write accepted when wr_en && wr_vld
- rd_en  input  1  pop request
- rd_vld  output  1  rd_data holds the head word; pop when rd_en && rd_vld
- rd_data  output  DATA_W  head word (FWFT)
- level  output  DEPTH_W+1  words held, including the prefetch stage
- almost_full  output  1  level >= AFULL_TH
- err_clr  input  1  clears sticky error flags
- ovf_err  output  1  sticky: write attempted while full
- udf_err  output  1  sticky: pop attempted while empty

## Operation
- Storage: 2^DEPTH_W-entry RAM with a registered synchronous read, plus a prefetch output stage. Total capacity is exactly DEPTH words; level counts every word held.
- Pointers: DEPTH_W-bit, wrapping naturally modulo DEPTH.
- wr_vld = (level < DEPTH). It is derived from registered state only. A same-cycle pop does not free space for a write in that cycle.
- When full, a write is ignored: contents and level are unchanged.
- When empty, a pop is ignored: rd_data is held and level is unchanged.
- Simultaneous accepted write and pop: level is unchanged.
- rd_data changes only on a pop or on refill of an empty output stage. It is held stable while rd_vld && !rd_en.
- flush: empties the FIFO next edge exactly as rst does, except ovf_err and udf_err keep their values. flush has priority over same-cycle wr_en and rd_en.
- rst: clears everything. Reset values: wr_vld=1, rd_vld=0, rd_data=0, level=0, almost_full=0, ovf_err=0, udf_err=0. Asserting rst mid-transfer discards all held words.

## Timing
- Write latency: a word accepted at edge E into an empty FIFO gives rd_vld=1 after edge E+2.
- Throughput: one word per cycle on each side. With rd_en held high and data available, there are no bubbles after the first rd_vld.
- level, almost_full and wr_vld update on the edge after the accepting or popping edge.
- Error flags set on the edge after the offending request. err_clr and a same-cycle set: set wins.

## Configuration
- SCALE_FIFO_ERR_EN defined: ovf_err and udf_err are implemented as described.
- SCALE_FIFO_ERR_EN undefined: ovf_err and udf_err are tied to 0, and err_clr is ignored. All ports remain present.

## Test plan
- Bench parameters for all scenarios: DATA_W=16, DEPTH_W=4, AFULL_TH=12.
- Reset then single write of 0x1234 at edge E -> rd_vld=1 and rd_data=0x1234 after E+2; level=1; wr_vld=1.
- 16 consecutive writes (0x0000..0x000F) -> almost_full rises when level reaches 12; wr_vld=0 at level 16. A 17th write of 0xDEAD is dropped and ovf_err=1. Reads then return 0x0000..0x000F in order with no bubbles.
- Full FIFO with wr_en and rd_en high together -> only the pop is taken and level goes 16 to 15. The next cycle, write and pop are both accepted and level stays 15.
- rd_en pulsed while empty after reset -> udf_err=1; err_clr for one cycle -> udf_err=0. Build without SCALE_FIFO_ERR_EN -> both flags stay 0.
- 40 writes with random rd_en -> output order intact across pointer wrap; level always equals writes accepted minus pops.
- Write 5 words, then flush and wr_en asserted in the same cycle -> level=0, rd_vld=0, and the same-cycle write is dropped. rst mid-burst -> every output at its reset value on the next edge.
